alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one clocked ALU (A, B, CTRL[1:0] -> R, zero, ovf) between two requesters.
//  Round-robin arbitration, valid/ready handshakes, one operation in flight.
//  Sits between the issue logic and the ALU instance; drives the ALU operands.
//  Returns each result with the id of the requester that issued it.
// PARAMETERS
//  WIDTH    32  operand/result width
//  ALU_LAT  1   clock edges from ALU operand change to R/zero/ovf valid (>=0)
//  CNT_W    16  grant counter width (used only with ALU_ARB_STATS_EN)
// PORTS
//  clk              in   1       system clock, rising edge
//  reset            in   1       asynchronous, active-high
//  reqN_valid       in   1       N=0,1: request present
//  reqN_ready       out  1       N=0,1: request accepted this cycle
//  reqN_a, reqN_b   in   WIDTH   N=0,1: operands
//  reqN_ctrl        in   2       N=0,1: ALU op select, passed through unchanged
//  alu_a, alu_b     out  WIDTH   to ALU A/B (registered)
//  alu_ctrl         out  2       to ALU CTRL (registered)
//  alu_r            in   WIDTH   from ALU R
//  alu_zero, alu_ovf in  1       from ALU flags
//  rsp_valid        out  1       result available
//  rsp_ready        in   1       consumer takes result
//  rsp_id           out  1       requester that issued the result
//  rsp_r            out  WIDTH   captured alu_r
//  rsp_zero, rsp_ovf out 1       captured flags
// BEHAVIOUR
//  Reset (any time, incl. mid-op): state=IDLE, alu_a/alu_b/alu_ctrl=0, rsp_*=0,
//   rsp_valid=0, wait counter=0, last_grant=1; in-flight op discarded.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: grant = only valid requester; both valid -> requester != last_grant.
//   reqN_ready=1 (combinational, from valid) only for the granted N in IDLE;
//   at most one ready per cycle. Never high outside IDLE.
//   On accept edge: latch operands/ctrl into alu_*, rsp_id=N, last_grant=N,
//   cnt=ALU_LAT, go WAIT.
//  WAIT: cnt!=0 -> cnt-1. cnt==0 -> capture alu_r/zero/ovf into rsp_*,
//   rsp_valid=1, go RESP.
//  Latency: rsp_valid rises ALU_LAT+1 cycles after the accept edge.
//  RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0 (no drop).
//   rsp_valid&rsp_ready -> rsp_valid=0, go IDLE. Next accept no earlier than
//   the following cycle; back-to-back period = ALU_LAT+3 cycles.
//  alu_* hold their values outside the accept edge; rsp_r/zero/ovf hold last
//   result after the handshake.
//  Request dropped (valid low) before ready: no effect, no grant recorded.
//  Single requester always wins regardless of last_grant.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: adds outputs grant_cnt0, grant_cnt1 [CNT_W-1:0];
//   +1 on each accept of that requester, saturate at all-ones, 0 on reset.
//  Undefined: ports and counters absent; CNT_W unused; behaviour otherwise same.
// TESTING
//  1 Reset then req0 a=5,b=3,ctrl=0 only -> req0_ready same cycle, alu_a=5,alu_b=3;
//    rsp_valid ALU_LAT+1 cycles later, rsp_id=0, rsp_r=alu_r.
//  2 req0 and req1 valid continuously, rsp_ready=1 -> grants 0,1,0,1 alternate;
//    rsp_id sequence 0,1,0,1; ready never high for both.
//  3 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, reqN_ready=0;
//    rsp_ready=1 -> IDLE next cycle.
//  4 Assert reset in WAIT -> rsp_valid=0, alu_*=0 at once; first grant after
//    reset with both valid goes to req0.
//  5 ALU model returns R=0, zero=1, ovf=1 for ALU_LAT=0 and 3 -> rsp_zero=1,
//    rsp_ovf=1 at latency 1 and 4.
//  6 With ALU_ARB_STATS_EN, CNT_W=2: 5 req1 accepts -> grant_cnt1=3 (saturated),
//    grant_cnt0=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one clocked ALU between two requesters, with one operation in flight at a time.
// Optional: define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_zero,
  output logic             rsp_ovf
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int LCW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [LCW-1:0]   r_cnt;
  logic             r_last;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_ctrl;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_r;
  logic             r_rsp_zero;
  logic             r_rsp_ovf;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_cnt_done;
  logic             w_capture;
  logic             w_handshake;

  // Arbitration: a lone requester always wins; on contention the one not granted last goes.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_gnt0      = w_idle && req0_valid && (!req1_valid || r_last);
    w_gnt1      = w_idle && req1_valid && (!req0_valid || !r_last);
    w_accept    = w_gnt0 || w_gnt1;
    w_cnt_done  = (r_cnt == '0);
    w_capture   = (r_state == S_WAIT) && w_cnt_done;
    w_handshake = (r_state == S_RESP) && rsp_ready;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_WAIT;
      S_WAIT:  if (w_cnt_done)  w_next = S_RESP;
      S_RESP:  if (rsp_ready)   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Control: wait counter and round-robin memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      if (w_accept) begin
        r_cnt  <= LCW'(ALU_LAT);
        r_last <= w_gnt1;
      end else if ((r_state == S_WAIT) && !w_cnt_done) begin
        r_cnt <= r_cnt - LCW'(1);
      end
    end
  end

  // Operand stage: ALU inputs only change on an accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctrl <= '0;
      r_rsp_id   <= 1'b0;
    end else if (w_accept) begin
      r_alu_a    <= w_gnt1 ? req1_a    : req0_a;
      r_alu_b    <= w_gnt1 ? req1_b    : req0_b;
      r_alu_ctrl <= w_gnt1 ? req1_ctrl : req0_ctrl;
      r_rsp_id   <= w_gnt1;
    end
  end

  // Result stage: captured once, then held until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_r     <= alu_r;
        r_rsp_zero  <= alu_zero;
        r_rsp_ovf   <= alu_ovf;
      end else if (w_handshake) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_gcnt0;
  logic [CNT_W-1:0] r_gcnt1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_gnt0) r_gcnt0 <= sat_inc(r_gcnt0);
      if (w_gnt1) r_gcnt1 <= sat_inc(r_gcnt1);
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
`endif

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_r      = r_rsp_r;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, randomized traffic and directed corner cases.
// A stand-in clocked ALU sits behind each DUT instance (ALU_LAT=3 main, ALU_LAT=0 secondary).
module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stand-in ALU behaviour: add/sub with signed overflow, and, or.
  function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] c);
    logic [W-1:0] r;
    logic         o;
    case (c)
      2'd0: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      2'd1: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      2'd2: begin r = a & b; o = 1'b0; end
      default: begin r = a | b; o = 1'b0; end
    endcase
    return {o, (r == '0), r};
  endfunction

  // Main DUT signals
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [1:0]   alu_ctrl;
  logic         alu_zero, alu_ovf;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf;
  logic [W-1:0] rsp_r;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  logic [W+1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_a, alu_b, alu_ctrl);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_ovf, alu_zero, alu_r} = alu_pipe[LAT-1];

  // Secondary DUT with a combinational ALU (ALU_LAT=0)
  logic         b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [W-1:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic [1:0]   b_req0_ctrl, b_req1_ctrl;
  logic [W-1:0] b_alu_a, b_alu_b, b_alu_r, b_rsp_r;
  logic [1:0]   b_alu_ctrl;
  logic         b_alu_zero, b_alu_ovf, b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero, b_rsp_ovf;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] b_grant_cnt0, b_grant_cnt1;
`endif

  alu_arbiter #(.WIDTH(W), .ALU_LAT(0), .CNT_W(CW)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b),
    .req0_ctrl(b_req0_ctrl),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a), .req1_b(b_req1_b),
    .req1_ctrl(b_req1_ctrl),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_ctrl(b_alu_ctrl),
    .alu_r(b_alu_r), .alu_zero(b_alu_zero), .alu_ovf(b_alu_ovf),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_r(b_rsp_r),
    .rsp_zero(b_rsp_zero), .rsp_ovf(b_rsp_ovf)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
`endif
  );

  assign {b_alu_ovf, b_alu_zero, b_alu_r} = alu_f(b_alu_a, b_alu_b, b_alu_ctrl);

  // Reference model of the main DUT, at transaction level
  logic         m_busy;
  int           m_age;
  logic         m_last;
  logic         m_id;
  logic [W+1:0] m_res;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_c;
  int           m_cnt0, m_cnt1;

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
    m_res = '0; m_a = '0; m_b = '0; m_c = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic step();
    logic e0, e1, ev;
    #1;
    ev = m_busy && (m_age >= LAT + 1);
    e0 = !m_busy && req0_valid && (!req1_valid || m_last);
    e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_r", rsp_r, m_res[W-1:0]);
      chk("rsp_zero", rsp_zero, m_res[W]);
      chk("rsp_ovf", rsp_ovf, m_res[W+1]);
    end
    @(posedge clk);
    #1;
    if (e0 || e1) begin
      m_busy = 1'b1; m_age = 0; m_last = e1; m_id = e1;
      m_a = e1 ? req1_a : req0_a;
      m_b = e1 ? req1_b : req0_b;
      m_c = e1 ? req1_ctrl : req0_ctrl;
      m_res = alu_f(m_a, m_b, m_c);
      if (e0 && m_cnt0 < (1 << CW) - 1) m_cnt0++;
      if (e1 && m_cnt1 < (1 << CW) - 1) m_cnt1++;
    end else if (ev && rsp_ready) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_age++;
    end
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", alu_ctrl, m_c);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt0);
    chk("grant_cnt1", grant_cnt1, m_cnt1);
`endif
  endtask

  task automatic check_reset_outputs();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_rsp_flags", {rsp_zero, rsp_ovf}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return '0;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_ctrl = '0; req1_ctrl = '0; rsp_ready = 1'b0;
    b_req0_valid = 0; b_req1_valid = 0; b_req0_a = '0; b_req0_b = '0; b_req1_a = '0;
    b_req1_b = '0; b_req0_ctrl = '0; b_req1_ctrl = '0; b_rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // ALU_LAT=0 instance: ready same cycle, result one cycle after accept, then flags case
    b_req0_valid = 1; b_req0_a = 32'd5; b_req0_b = 32'd3; b_req0_ctrl = 2'd0;
    #1;
    chk("l0_ready0", b_req0_ready, 1);
    chk("l0_ready1", b_req1_ready, 0);
    @(posedge clk); #1;
    b_req0_valid = 0;
    chk("l0_alu_a", b_alu_a, 5);
    chk("l0_alu_b", b_alu_b, 3);
    chk("l0_no_early_valid", b_rsp_valid, 0);
    @(posedge clk); #1;
    chk("l0_rsp_valid", b_rsp_valid, 1);
    chk("l0_rsp_id", b_rsp_id, 0);
    chk("l0_rsp_r", b_rsp_r, 8);
    chk("l0_rsp_flags", {b_rsp_zero, b_rsp_ovf}, 2'b00);
    @(posedge clk); #1;
    chk("l0_rsp_done", b_rsp_valid, 0);
    b_req1_valid = 1; b_req1_a = 32'h8000_0000; b_req1_b = 32'h8000_0000; b_req1_ctrl = 2'd0;
    @(posedge clk); #1;
    b_req1_valid = 0;
    @(posedge clk); #1;
    chk("l0_flag_valid", b_rsp_valid, 1);
    chk("l0_flag_id", b_rsp_id, 1);
    chk("l0_flag_r", b_rsp_r, 0);
    chk("l0_flag_zero", b_rsp_zero, 1);
    chk("l0_flag_ovf", b_rsp_ovf, 1);

    // Single requester after reset, then let the result drain
    rsp_ready = 1'b1;
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 2'd0;
    step();
    req0_valid = 0;
    repeat (LAT + 3) step();

    // Both requesters continuously: alternating grants
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6 * (LAT + 3); i++) begin
      req0_a = rand_op(); req0_b = rand_op(); req0_ctrl = 2'($urandom_range(0, 3));
      req1_a = rand_op(); req1_b = rand_op(); req1_ctrl = 2'($urandom_range(0, 3));
      step();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (LAT + 3) step();

    // Consumer stall in RESP with req0 pending
    req1_valid = 1; req1_a = 32'hdead_beef; req1_b = 32'h0123_4567; req1_ctrl = 2'd3;
    rsp_ready = 1'b0;
    step();
    req1_valid = 0; req0_valid = 1; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000;
    req0_ctrl = 2'd0;
    repeat (LAT + 1 + 5) step();
    rsp_ready = 1'b1;
    repeat (LAT + 4) step();
    req0_valid = 0;
    repeat (LAT + 3) step();

    // Reset asserted mid-operation
    req0_valid = 1; req0_a = 32'h11; req0_b = 32'h22; req0_ctrl = 2'd2;
    step();
    req0_valid = 0;
    step();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1; req1_valid = 1; req0_a = 32'd7; req1_a = 32'd9;
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (LAT + 3) step();

    // Repeated req1 traffic (saturates the grant counter when stats are built in)
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1; req1_a = $urandom(); req1_b = $urandom(); req1_ctrl = 2'($urandom_range(0, 3));
      step();
      req1_valid = 0;
      repeat (LAT + 2) step();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 99) < 55);
      req1_valid = ($urandom_range(0, 99) < 55);
      req0_a = rand_op(); req0_b = rand_op(); req0_ctrl = 2'($urandom_range(0, 3));
      req1_a = rand_op(); req1_b = rand_op(); req1_ctrl = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
